// File: rtl/branch_predictor_2bit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_2bit_if
// Brief    : Fetch-lookup / EX-resolution bundle for the 2-bit branch predictor
// Revision : 1.0 - initial release
// ============================================================================
interface branch_predictor_2bit_if;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic        res_pred;
    logic        miss;
    logic [15:0] resolved;

    modport master (
        output pred_valid, pred_pc, res_valid, res_pc, res_taken, res_pred,
        input  pred_taken, miss, resolved
    );

    modport slave (
        input  pred_valid, pred_pc, res_valid, res_pc, res_taken, res_pred,
        output pred_taken, miss, resolved
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_2bit.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_2bit
// Brief    : PC-indexed table of 2-bit saturating counters with miss pulse
//            and resolution counter
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_2bit #(
    parameter int         INDEX_BITS  = 4,
    parameter logic [1:0] RESET_STATE = 2'b01
) (
    input  wire logic               clock,
    input  wire logic               reset_n,
    branch_predictor_2bit_if.slave  bus
);
    localparam int c_ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            r_table [c_ENTRIES];
    logic                  r_miss;
    logic [15:0]           r_resolved;
    logic [INDEX_BITS-1:0] w_pred_idx;
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic                  w_unused;

    // Word-aligned index; upper PC bits alias onto the same entries.
    assign w_pred_idx = bus.pred_pc[INDEX_BITS+1:2];
    assign w_upd_idx  = bus.res_pc[INDEX_BITS+1:2];
    assign w_unused   = ^{bus.pred_pc[31:INDEX_BITS+2], bus.pred_pc[1:0],
                          bus.res_pc[31:INDEX_BITS+2], bus.res_pc[1:0]};

    // Read is of the registered table, so a same-cycle update is seen next cycle.
    assign bus.pred_taken = bus.pred_valid & r_table[w_pred_idx][1];
    assign bus.miss       = r_miss;
    assign bus.resolved   = r_resolved;

    generate
        for (genvar i = 0; i < c_ENTRIES; i++) begin : g_entry
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_table[i] <= RESET_STATE;
                end else if (bus.res_valid && (w_upd_idx == INDEX_BITS'(i))) begin
                    if (bus.res_taken) begin
                        if (r_table[i] != 2'b11) begin
                            r_table[i] <= r_table[i] + 2'b01;
                        end
                    end else begin
                        if (r_table[i] != 2'b00) begin
                            r_table[i] <= r_table[i] - 2'b01;
                        end
                    end
                end
            end
        end
    endgenerate

    // Miss compares the prediction carried down the pipe, not the table.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_miss     <= 1'b0;
            r_resolved <= 16'h0000;
        end else begin
            r_miss <= bus.res_valid & (bus.res_pred != bus.res_taken);
            if (bus.res_valid) begin
                r_resolved <= r_resolved + 16'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_2bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor_2bit
// Brief    : Directed self-checking bench for branch_predictor_2bit
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_2bit;
    logic clock;
    logic reset_n;
    int   nvec;
    int   nerr;

    branch_predictor_2bit_if bus();

    branch_predictor_2bit #(
        .INDEX_BITS  (4),
        .RESET_STATE (2'b01)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken, input logic pred);
        bus.res_valid = 1'b1;
        bus.res_pc    = pc;
        bus.res_taken = taken;
        bus.res_pred  = pred;
    endtask

    task automatic lookup(input logic [31:0] pc);
        bus.pred_valid = 1'b1;
        bus.pred_pc    = pc;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        reset_n        = 1'b0;
        bus.pred_valid = 1'b0;
        bus.pred_pc    = 32'h0;
        bus.res_valid  = 1'b0;
        bus.res_pc     = 32'h0;
        bus.res_taken  = 1'b0;
        bus.res_pred   = 1'b0;

        // Reset state and initial weakly-not-taken lookup
        tick;
        tick;
        chk("rst_miss", {31'd0, bus.miss}, 32'd0);
        chk("rst_resolved", {16'd0, bus.resolved}, 32'd0);
        reset_n = 1'b1;
        lookup(32'h40);
        #1 chk("rst_pred_40", {31'd0, bus.pred_taken}, 32'd0);

        // First mispredict: 01 -> 10
        resolve(32'h40, 1'b1, 1'b0);
        tick;
        bus.res_valid = 1'b0;
        chk("miss_pulse", {31'd0, bus.miss}, 32'd1);
        chk("resolved_1", {16'd0, bus.resolved}, 32'd1);
        chk("pred_40_taken", {31'd0, bus.pred_taken}, 32'd1);
        tick;
        chk("miss_clear", {31'd0, bus.miss}, 32'd0);
        bus.pred_valid = 1'b0;
        #1 chk("pred_invalid", {31'd0, bus.pred_taken}, 32'd0);

        // Saturate at 11, then one not-taken back to 10
        for (int k = 0; k < 4; k++) begin
            resolve(32'h40, 1'b1, 1'b1);
            tick;
            chk("sat_no_miss", {31'd0, bus.miss}, 32'd0);
        end
        resolve(32'h40, 1'b0, 1'b1);
        tick;
        bus.res_valid = 1'b0;
        lookup(32'h40);
        #1 chk("sat_then_nt_pred", {31'd0, bus.pred_taken}, 32'd1);
        chk("resolved_6", {16'd0, bus.resolved}, 32'd6);

        // Same-cycle lookup/update on 0x80 (aliases 0x40, entry 10)
        lookup(32'h80);
        resolve(32'h80, 1'b0, 1'b1);
        #1 chk("same_cyc_pre", {31'd0, bus.pred_taken}, 32'd1);
        tick;
        bus.res_valid = 1'b0;
        #1 chk("same_cyc_post", {31'd0, bus.pred_taken}, 32'd0);
        chk("same_cyc_miss", {31'd0, bus.miss}, 32'd1);

        // Different indices same cycle are independent
        lookup(32'h40);
        resolve(32'h08, 1'b1, 1'b1);
        tick;
        bus.res_valid = 1'b0;
        #1 chk("indep_idx0", {31'd0, bus.pred_taken}, 32'd0);
        lookup(32'h08);
        #1 chk("indep_idx2", {31'd0, bus.pred_taken}, 32'd1);
        chk("resolved_8", {16'd0, bus.resolved}, 32'd8);

        // Three back-to-back mispredicts through aliasing PCs 0x04 / 0x44
        resolve(32'h04, 1'b1, 1'b0);
        tick;
        chk("b2b_miss_1", {31'd0, bus.miss}, 32'd1);
        resolve(32'h44, 1'b1, 1'b0);
        tick;
        chk("b2b_miss_2", {31'd0, bus.miss}, 32'd1);
        resolve(32'h04, 1'b1, 1'b0);
        tick;
        chk("b2b_miss_3", {31'd0, bus.miss}, 32'd1);
        bus.res_valid = 1'b0;
        tick;
        chk("b2b_miss_end", {31'd0, bus.miss}, 32'd0);
        lookup(32'h44);
        #1 chk("alias_44", {31'd0, bus.pred_taken}, 32'd1);
        // Entry 1 is 11; two not-taken on the alias leave it 01
        resolve(32'h44, 1'b0, 1'b1);
        tick;
        resolve(32'h44, 1'b0, 1'b1);
        tick;
        bus.res_valid = 1'b0;
        lookup(32'h04);
        #1 chk("alias_04_down", {31'd0, bus.pred_taken}, 32'd0);

        // Saturate at 00 on entry 3, then two taken -> 10
        resolve(32'h0C, 1'b0, 1'b0);
        tick;
        tick;
        resolve(32'h0C, 1'b1, 1'b1);
        tick;
        tick;
        bus.res_valid = 1'b0;
        lookup(32'h0C);
        #1 chk("sat_low", {31'd0, bus.pred_taken}, 32'd1);
        chk("resolved_17", {16'd0, bus.resolved}, 32'd17);

        // Asynchronous reset during a miss pulse, with res_valid held
        resolve(32'h10, 1'b1, 1'b0);
        tick;
        chk("pre_rst_miss", {31'd0, bus.miss}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("async_rst_miss", {31'd0, bus.miss}, 32'd0);
        chk("async_rst_resolved", {16'd0, bus.resolved}, 32'd0);
        tick;
        chk("rst_dominates", {16'd0, bus.resolved}, 32'd0);
        lookup(32'h08);
        #1 chk("rst_table", {31'd0, bus.pred_taken}, 32'd0);
        bus.res_valid = 1'b0;
        tick;
        reset_n = 1'b1;

        // Resume after reset release
        resolve(32'h08, 1'b1, 1'b1);
        tick;
        #1 chk("resume_pred", {31'd0, bus.pred_taken}, 32'd1);
        chk("resume_resolved", {16'd0, bus.resolved}, 32'd1);

        // Run RESOLVED to FFFF and wrap it with a mispredict
        resolve(32'h10, 1'b1, 1'b1);
        repeat (65534) tick;
        chk("resolved_ffff", {16'd0, bus.resolved}, 32'h0000FFFF);
        resolve(32'h10, 1'b0, 1'b1);
        tick;
        bus.res_valid = 1'b0;
        chk("resolved_wrap", {16'd0, bus.resolved}, 32'd0);
        chk("wrap_miss", {31'd0, bus.miss}, 32'd1);
        tick;
        chk("wrap_hold", {16'd0, bus.resolved}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
`default_nettype wire
